// File: rtl/rsa_pkg.sv
// ---------------------------------------------------------------------------
// rsa_pkg
//   Shared definitions for the RSA256 UART wrapper: controller state and
//   operand-phase enums, UART register word addresses and status bit
//   positions, and the byte counts of one operand and of one reply.
// ---------------------------------------------------------------------------
package rsa_pkg;

  localparam logic [4:0] RX_BASE     = 5'd0;
  localparam logic [4:0] TX_BASE     = 5'd4;
  localparam logic [4:0] STATUS_BASE = 5'd8;

  localparam int RX_OK_BIT = 7;
  localparam int TX_OK_BIT = 6;

  // 32 bytes make one 256-bit operand; only 31 bytes of the result go back
  localparam int BYTES_IN  = 32;
  localparam int BYTES_OUT = 31;

  typedef enum logic [2:0] {
    S_QUERY_RX,
    S_GET_DATA,
    S_WAIT_CALC,
    S_QUERY_TX,
    S_SEND_DATA
  } state_t;

  typedef enum logic [1:0] {
    PH_N,
    PH_D,
    PH_A
  } phase_t;

endpackage

// File: rtl/rsa256_uart_wrapper.sv
// ---------------------------------------------------------------------------
// rsa256_uart_wrapper
//   Avalon-MM master bridging a UART peripheral and the RSA256 core. After
//   reset it receives 32 bytes of modulus N and 32 bytes of key d, then loops:
//   receive 32 bytes of ciphertext, pulse the core start, wait for the core to
//   finish, and write 31 result bytes back to the UART.
//
// Ports
//   i_clk, i_rst        clock; synchronous active-high reset
//   o_avm_address       Avalon word address (UART rx / tx / status)
//   o_avm_read          Avalon read request
//   i_avm_readdata      Avalon read data, byte in [7:0]
//   o_avm_write         Avalon write request
//   o_avm_writedata     Avalon write data, byte in [7:0], upper bits zero
//   i_avm_waitrequest   Avalon stall; a request completes when it is low
//   o_core_start        one-cycle start pulse to the core
//   o_core_a/d/n        ciphertext / key / modulus to the core
//   i_core_a_pow_d      core result
//   i_core_finished     one-cycle completion pulse from the core
// ---------------------------------------------------------------------------
module rsa256_uart_wrapper
  import rsa_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  output logic [4:0]   o_avm_address,
  output logic         o_avm_read,
  input  logic [31:0]  i_avm_readdata,
  output logic         o_avm_write,
  output logic [31:0]  o_avm_writedata,
  input  logic         i_avm_waitrequest,
  output logic         o_core_start,
  output logic [255:0] o_core_a,
  output logic [255:0] o_core_d,
  output logic [255:0] o_core_n,
  input  logic [255:0] i_core_a_pow_d,
  input  logic         i_core_finished
);

  state_t       state, state_nxt;
  phase_t       phase, phase_nxt;
  logic [4:0]   cnt, cnt_nxt;
  logic [255:0] n_reg, n_nxt;
  logic [255:0] d_reg, d_nxt;
  logic [255:0] a_reg, a_nxt;
  // Result byte 31 is never transmitted, so only 248 bits are kept
  logic [247:0] tx_reg, tx_nxt;
  logic [4:0]   addr, addr_nxt;
  logic         rd, rd_nxt;
  logic         wr, wr_nxt;
  logic [31:0]  wdata, wdata_nxt;
  logic         start, start_nxt;

  logic         rd_accept;
  logic         wr_accept;
  logic [7:0]   rx_byte;
  logic         unused_bits;

  assign rd_accept   = rd & ~i_avm_waitrequest;
  assign wr_accept   = wr & ~i_avm_waitrequest;
  assign rx_byte     = i_avm_readdata[7:0];
  assign unused_bits = ^{i_avm_readdata[31:8], i_core_a_pow_d[255:248]};

  assign o_avm_address   = addr;
  assign o_avm_read      = rd;
  assign o_avm_write     = wr;
  assign o_avm_writedata = wdata;
  assign o_core_start    = start;
  assign o_core_n        = n_reg;
  assign o_core_d        = d_reg;
  assign o_core_a        = a_reg;

  // State and datapath registers; every bus and core output is registered
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= S_QUERY_RX;
      phase  <= PH_N;
      cnt    <= '0;
      n_reg  <= '0;
      d_reg  <= '0;
      a_reg  <= '0;
      tx_reg <= '0;
      addr   <= STATUS_BASE;
      rd     <= 1'b0;
      wr     <= 1'b0;
      wdata  <= '0;
      start  <= 1'b0;
    end else begin
      state  <= state_nxt;
      phase  <= phase_nxt;
      cnt    <= cnt_nxt;
      n_reg  <= n_nxt;
      d_reg  <= d_nxt;
      a_reg  <= a_nxt;
      tx_reg <= tx_nxt;
      addr   <= addr_nxt;
      rd     <= rd_nxt;
      wr     <= wr_nxt;
      wdata  <= wdata_nxt;
      start  <= start_nxt;
    end
  end

  // Next-state logic. Each bus state first raises its request, then holds it
  // until an unstalled cycle, and drops it in the cycle after acceptance.
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    cnt_nxt   = cnt;
    n_nxt     = n_reg;
    d_nxt     = d_reg;
    a_nxt     = a_reg;
    tx_nxt    = tx_reg;
    addr_nxt  = addr;
    rd_nxt    = rd;
    wr_nxt    = wr;
    wdata_nxt = wdata;
    start_nxt = 1'b0;

    case (state)
      S_QUERY_RX: begin
        if (!rd) begin
          rd_nxt   = 1'b1;
          addr_nxt = STATUS_BASE;
        end else if (rd_accept) begin
          rd_nxt = 1'b0;
          if (i_avm_readdata[RX_OK_BIT]) begin
            state_nxt = S_GET_DATA;
          end
        end
      end

      S_GET_DATA: begin
        if (!rd) begin
          rd_nxt   = 1'b1;
          addr_nxt = RX_BASE;
        end else if (rd_accept) begin
          rd_nxt = 1'b0;
          case (phase)
            PH_N:    n_nxt = {n_reg[247:0], rx_byte};
            PH_D:    d_nxt = {d_reg[247:0], rx_byte};
            default: a_nxt = {a_reg[247:0], rx_byte};
          endcase
          if (cnt == 5'(BYTES_IN - 1)) begin
            cnt_nxt   = '0;
            state_nxt = S_QUERY_RX;
            case (phase)
              PH_N: phase_nxt = PH_D;
              PH_D: phase_nxt = PH_A;
              default: begin
                state_nxt = S_WAIT_CALC;
                start_nxt = 1'b1;
              end
            endcase
          end else begin
            cnt_nxt   = cnt + 5'd1;
            state_nxt = S_QUERY_RX;
          end
        end
      end

      S_WAIT_CALC: begin
        if (i_core_finished) begin
          tx_nxt    = i_core_a_pow_d[247:0];
          state_nxt = S_QUERY_TX;
        end
      end

      S_QUERY_TX: begin
        if (!rd) begin
          rd_nxt   = 1'b1;
          addr_nxt = STATUS_BASE;
        end else if (rd_accept) begin
          rd_nxt = 1'b0;
          if (i_avm_readdata[TX_OK_BIT]) begin
            state_nxt = S_SEND_DATA;
          end
        end
      end

      S_SEND_DATA: begin
        if (!wr) begin
          wr_nxt    = 1'b1;
          addr_nxt  = TX_BASE;
          wdata_nxt = {24'd0, tx_reg[247:240]};
        end else if (wr_accept) begin
          wr_nxt = 1'b0;
          tx_nxt = {tx_reg[239:0], 8'h00};
          // Phase stays at A so the next message reuses the stored N and d
          if (cnt == 5'(BYTES_OUT - 1)) begin
            cnt_nxt   = '0;
            state_nxt = S_QUERY_RX;
          end else begin
            cnt_nxt   = cnt + 5'd1;
            state_nxt = S_QUERY_TX;
          end
        end
      end

      default: state_nxt = S_QUERY_RX;
    endcase
  end

endmodule

// File: tb/tb_rsa256_uart_wrapper.sv
// ---------------------------------------------------------------------------
// tb_rsa256_uart_wrapper
//   Drives the wrapper with a behavioural UART slave (byte queues, optional
//   waitrequest stalls, status bits that can be held off for a number of
//   polls) and a behavioural RSA core that computes a^d mod n by plain
//   modular exponentiation. Returned bytes are compared to the reference.
// ---------------------------------------------------------------------------
module tb_rsa256_uart_wrapper;

  localparam logic [4:0] A_RX     = 5'd0;
  localparam logic [4:0] A_TX     = 5'd4;
  localparam logic [4:0] A_STATUS = 5'd8;
  localparam int         BUDGET   = 12000;

  logic         i_clk;
  logic         i_rst;
  logic [4:0]   o_avm_address;
  logic         o_avm_read;
  logic [31:0]  i_avm_readdata;
  logic         o_avm_write;
  logic [31:0]  o_avm_writedata;
  logic         i_avm_waitrequest;
  logic         o_core_start;
  logic [255:0] o_core_a;
  logic [255:0] o_core_d;
  logic [255:0] o_core_n;
  logic [255:0] i_core_a_pow_d;
  logic         i_core_finished;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] rxQ[$];
  logic [7:0] txQ[$];
  int stallCycles   = 0;
  int rxBlockTarget = 0;
  int rxBlockedCnt  = 0;
  int txBlockTarget = 0;
  int txBlockedCnt  = 0;
  int statusReads   = 0;
  int rxReads       = 0;
  int writesSeen    = 0;
  int protoErrors   = 0;
  int startPulses   = 0;
  int spuriousReq   = 0;
  int spuriousDone  = 0;

  bit           inAccess = 0;
  int           stallLeft = 0;
  logic [4:0]   accAddr;
  logic         accRd;
  logic         accWr;
  logic [31:0]  accWdata;
  logic [31:0]  rword;
  int           busyCnt = 0;
  logic [255:0] coreResult;
  logic [255:0] seenN, seenD, seenA;

  rsa256_uart_wrapper dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .o_avm_address     (o_avm_address),
    .o_avm_read        (o_avm_read),
    .i_avm_readdata    (i_avm_readdata),
    .o_avm_write       (o_avm_write),
    .o_avm_writedata   (o_avm_writedata),
    .i_avm_waitrequest (i_avm_waitrequest),
    .o_core_start      (o_core_start),
    .o_core_a          (o_core_a),
    .o_core_d          (o_core_d),
    .o_core_n          (o_core_n),
    .i_core_a_pow_d    (i_core_a_pow_d),
    .i_core_finished   (i_core_finished)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  function automatic longint unsigned modexp(longint unsigned b, longint unsigned e,
                                             longint unsigned m);
    longint unsigned r;
    r = 1 % m;
    b = b % m;
    while (e != 0) begin
      if (e[0]) r = (r * b) % m;
      b = (b * b) % m;
      e = e >> 1;
    end
    return r;
  endfunction

  // UART slave: decides waitrequest and read data at each falling edge
  initial begin
    i_avm_waitrequest = 1'b0;
    i_avm_readdata    = '0;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        inAccess          = 0;
        i_avm_waitrequest = 1'b0;
      end else if (o_avm_read || o_avm_write) begin
        if (o_avm_read && o_avm_write) protoErrors++;
        if (!inAccess) begin
          inAccess  = 1;
          stallLeft = stallCycles;
          accAddr   = o_avm_address;
          accRd     = o_avm_read;
          accWr     = o_avm_write;
          accWdata  = o_avm_writedata;
        end else if (o_avm_address !== accAddr || o_avm_read !== accRd ||
                     o_avm_write !== accWr || o_avm_writedata !== accWdata) begin
          protoErrors++;
        end
        if (stallLeft > 0) begin
          i_avm_waitrequest = 1'b1;
          i_avm_readdata    = $urandom;
          stallLeft--;
        end else begin
          i_avm_waitrequest = 1'b0;
          inAccess          = 0;
          if (o_avm_read) begin
            rword = $urandom;
            if (o_avm_address == A_STATUS) begin
              statusReads++;
              rword[7] = (rxQ.size() > 0) && (rxBlockedCnt >= rxBlockTarget);
              rword[6] = (txBlockedCnt >= txBlockTarget);
              if (rxQ.size() > 0 && rxBlockedCnt < rxBlockTarget) rxBlockedCnt++;
              else if (rxQ.size() == 0 && txBlockedCnt < txBlockTarget) txBlockedCnt++;
            end else if (o_avm_address == A_RX) begin
              rxReads++;
              if (rxBlockedCnt < rxBlockTarget || rxQ.size() == 0) protoErrors++;
              if (rxQ.size() > 0) rword[7:0] = rxQ.pop_front();
            end else begin
              protoErrors++;
            end
            i_avm_readdata = rword;
          end else begin
            writesSeen++;
            if (o_avm_address != A_TX || o_avm_writedata[31:8] != 24'd0 ||
                txBlockedCnt < txBlockTarget) protoErrors++;
            txQ.push_back(o_avm_writedata[7:0]);
          end
        end
      end else begin
        inAccess          = 0;
        i_avm_waitrequest = 1'b0;
      end
    end
  end

  // Behavioural RSA core: fixed latency, result from the operands at start
  initial begin
    i_core_finished = 1'b0;
    i_core_a_pow_d  = '0;
    forever begin
      @(negedge i_clk);
      i_core_finished = 1'b0;
      if (i_rst) busyCnt = 0;
      if (spuriousDone != spuriousReq) begin
        spuriousDone++;
        i_core_finished = 1'b1;
        for (int k = 0; k < 8; k++) i_core_a_pow_d[k*32 +: 32] = $urandom;
      end else if (busyCnt > 0) begin
        busyCnt--;
        if (busyCnt == 0) begin
          i_core_finished = 1'b1;
          i_core_a_pow_d  = coreResult;
        end
      end
      if (o_core_start && !i_rst) begin
        startPulses++;
        seenN = o_core_n;
        seenD = o_core_d;
        seenA = o_core_a;
        if (o_core_n[255:32] == '0 && o_core_d[255:32] == '0 &&
            o_core_a[255:32] == '0 && o_core_n[31:0] != 32'd0)
          coreResult = 256'(modexp(64'(o_core_a[31:0]), 64'(o_core_d[31:0]),
                                   64'(o_core_n[31:0])));
        else
          coreResult = '1;
        busyCnt = 12;
      end
    end
  end

  task automatic push_value(input logic [255:0] v);
    for (int i = 31; i >= 0; i--) rxQ.push_back(v[i*8 +: 8]);
  endtask

  task automatic wait_reply(output logic [7:0] got[31], output bit timedOut);
    int cyc;
    cyc = 0;
    while (txQ.size() < 31 && cyc < BUDGET) begin
      @(negedge i_clk);
      cyc++;
    end
    timedOut = (txQ.size() < 31);
    for (int k = 0; k < 31; k++) got[k] = (k < txQ.size()) ? txQ[k] : 8'hxx;
  endtask

  task automatic do_cipher(input logic [255:0] a, output logic [7:0] got[31],
                           output bit timedOut);
    txQ.delete();
    push_value(a);
    wait_reply(got, timedOut);
  endtask

  task automatic do_reset();
    @(posedge i_clk);
    #1 i_rst = 1'b1;
    rxQ.delete();
    txQ.delete();
    stallCycles = 0;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    vectors++; if (o_avm_read !== 1'b0) begin miscompares++; $display("FAIL reset_read got %b want 0", o_avm_read); end
    vectors++; if (o_avm_write !== 1'b0) begin miscompares++; $display("FAIL reset_write got %b want 0", o_avm_write); end
    vectors++; if (o_avm_address !== A_STATUS) begin miscompares++; $display("FAIL reset_addr got %0d want %0d", o_avm_address, A_STATUS); end
    vectors++; if (o_avm_writedata !== 32'd0) begin miscompares++; $display("FAIL reset_wdata got %h want 0", o_avm_writedata); end
    vectors++; if (o_core_start !== 1'b0) begin miscompares++; $display("FAIL reset_start got %b want 0", o_core_start); end
    vectors++; if (o_core_n !== '0 || o_core_d !== '0 || o_core_a !== '0) begin
      miscompares++; $display("FAIL reset_operands got n=%h d=%h a=%h want 0", o_core_n[31:0], o_core_d[31:0], o_core_a[31:0]);
    end
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    vectors++; if (o_avm_read !== 1'b1 || o_avm_address !== A_STATUS) begin
      miscompares++; $display("FAIL first_poll got read=%b addr=%0d want read=1 addr=%0d", o_avm_read, o_avm_address, A_STATUS);
    end
  endtask

  task automatic test_basic();
    logic [7:0]   got[31];
    bit           to;
    int           sp0, rr0, w0, pe0;
    logic [255:0] expv;
    sp0 = startPulses; rr0 = rxReads; w0 = writesSeen; pe0 = protoErrors;
    push_value(256'd33);
    push_value(256'd7);
    do_cipher(256'd4, got, to);
    repeat (30) @(negedge i_clk);
    expv = 256'(modexp(4, 7, 33));
    vectors++; if (to) begin miscompares++; $display("FAIL basic_timeout got %0d bytes want 31", txQ.size()); end
    vectors++; if (startPulses - sp0 != 1) begin miscompares++; $display("FAIL basic_start_pulses got %0d want 1", startPulses - sp0); end
    vectors++; if (seenN !== 256'd33 || seenD !== 256'd7 || seenA !== 256'd4) begin
      miscompares++; $display("FAIL basic_operands got n=%h d=%h a=%h want 21/7/4", seenN[31:0], seenD[31:0], seenA[31:0]);
    end
    vectors++; if (rxReads - rr0 != 96) begin miscompares++; $display("FAIL basic_rx_reads got %0d want 96", rxReads - rr0); end
    vectors++; if (writesSeen - w0 != 31) begin miscompares++; $display("FAIL basic_writes got %0d want 31", writesSeen - w0); end
    vectors++; if (protoErrors != pe0) begin miscompares++; $display("FAIL basic_protocol got %0d errors want 0", protoErrors - pe0); end
    for (int k = 0; k < 31; k++) begin
      vectors++;
      if (got[k] !== expv[247-8*k -: 8]) begin
        miscompares++; $display("FAIL basic_byte%0d got %h want %h", k, got[k], expv[247-8*k -: 8]);
      end
    end
  endtask

  task automatic test_same_key();
    logic [7:0]   got[31];
    bit           to;
    int           sp0, rr0;
    logic [255:0] expv;
    sp0 = startPulses; rr0 = rxReads;
    do_cipher(256'd5, got, to);
    repeat (30) @(negedge i_clk);
    expv = 256'(modexp(5, 7, 33));
    vectors++; if (to) begin miscompares++; $display("FAIL samekey_timeout got %0d bytes want 31", txQ.size()); end
    vectors++; if (rxReads - rr0 != 32) begin miscompares++; $display("FAIL samekey_rx_reads got %0d want 32", rxReads - rr0); end
    vectors++; if (startPulses - sp0 != 1) begin miscompares++; $display("FAIL samekey_start_pulses got %0d want 1", startPulses - sp0); end
    for (int k = 0; k < 31; k++) begin
      vectors++;
      if (got[k] !== expv[247-8*k -: 8]) begin
        miscompares++; $display("FAIL samekey_byte%0d got %h want %h", k, got[k], expv[247-8*k -: 8]);
      end
    end
  endtask

  task automatic test_wait_stall();
    logic [7:0]   got[31];
    bit           to;
    int           rr0, w0, pe0;
    logic [255:0] expv;
    rr0 = rxReads; w0 = writesSeen; pe0 = protoErrors;
    stallCycles = 3;
    do_cipher(256'd4, got, to);
    repeat (40) @(negedge i_clk);
    stallCycles = 0;
    expv = 256'(modexp(4, 7, 33));
    vectors++; if (to) begin miscompares++; $display("FAIL stall_timeout got %0d bytes want 31", txQ.size()); end
    vectors++; if (protoErrors != pe0) begin miscompares++; $display("FAIL stall_protocol got %0d errors want 0", protoErrors - pe0); end
    vectors++; if (rxReads - rr0 != 32) begin miscompares++; $display("FAIL stall_rx_reads got %0d want 32", rxReads - rr0); end
    vectors++; if (writesSeen - w0 != 31) begin miscompares++; $display("FAIL stall_writes got %0d want 31", writesSeen - w0); end
    for (int k = 0; k < 31; k++) begin
      vectors++;
      if (got[k] !== expv[247-8*k -: 8]) begin
        miscompares++; $display("FAIL stall_byte%0d got %h want %h", k, got[k], expv[247-8*k -: 8]);
      end
    end
  endtask

  task automatic test_poll_block();
    logic [7:0]   got[31];
    bit           to;
    int           pe0;
    logic [255:0] expv;
    pe0 = protoErrors;
    txQ.delete();
    rxBlockTarget += 10;
    push_value(256'd5);
    txBlockTarget += 10;
    wait_reply(got, to);
    repeat (30) @(negedge i_clk);
    expv = 256'(modexp(5, 7, 33));
    vectors++; if (to) begin miscompares++; $display("FAIL block_timeout got %0d bytes want 31", txQ.size()); end
    vectors++; if (rxBlockedCnt != rxBlockTarget || txBlockedCnt != txBlockTarget) begin
      miscompares++; $display("FAIL block_polls got rx=%0d tx=%0d want rx=%0d tx=%0d", rxBlockedCnt, txBlockedCnt, rxBlockTarget, txBlockTarget);
    end
    vectors++; if (protoErrors != pe0) begin miscompares++; $display("FAIL block_protocol got %0d errors want 0", protoErrors - pe0); end
    vectors++; if (got[30] !== expv[7:0]) begin miscompares++; $display("FAIL block_last_byte got %h want %h", got[30], expv[7:0]); end
  endtask

  task automatic test_reset_midstream();
    logic [7:0]   got[31];
    bit           to;
    int           rr0, cyc;
    logic [255:0] expv;
    do_reset();
    rr0 = rxReads;
    push_value(256'd33);
    push_value(256'd7);
    cyc = 0;
    while (rxReads - rr0 < 42 && cyc < BUDGET) begin
      @(negedge i_clk);
      cyc++;
    end
    vectors++; if (rxReads - rr0 < 42) begin miscompares++; $display("FAIL midreset_reach got %0d reads want 42", rxReads - rr0); end
    @(posedge i_clk);
    #1 i_rst = 1'b1;
    rxQ.delete();
    txQ.delete();
    @(posedge i_clk);
    #1;
    vectors++; if (o_avm_read !== 1'b0 || o_avm_write !== 1'b0 || o_avm_address !== A_STATUS ||
                   o_avm_writedata !== 32'd0 || o_core_start !== 1'b0) begin
      miscompares++; $display("FAIL midreset_bus got rd=%b wr=%b addr=%0d wdata=%h start=%b want 0/0/8/0/0",
                              o_avm_read, o_avm_write, o_avm_address, o_avm_writedata, o_core_start);
    end
    vectors++; if (o_core_n !== '0 || o_core_d !== '0 || o_core_a !== '0) begin
      miscompares++; $display("FAIL midreset_operands got n=%h d=%h want 0", o_core_n[31:0], o_core_d[31:0]);
    end
    i_rst = 1'b0;
    push_value(256'd33);
    push_value(256'd7);
    do_cipher(256'd4, got, to);
    repeat (30) @(negedge i_clk);
    expv = 256'(modexp(4, 7, 33));
    vectors++; if (to) begin miscompares++; $display("FAIL midreset_timeout got %0d bytes want 31", txQ.size()); end
    vectors++; if (seenN !== 256'd33 || seenD !== 256'd7) begin
      miscompares++; $display("FAIL midreset_key got n=%h d=%h want 21/7", seenN[31:0], seenD[31:0]);
    end
    for (int k = 0; k < 31; k++) begin
      vectors++;
      if (got[k] !== expv[247-8*k -: 8]) begin
        miscompares++; $display("FAIL midreset_byte%0d got %h want %h", k, got[k], expv[247-8*k -: 8]);
      end
    end
  endtask

  task automatic test_spurious_finish();
    logic [7:0]   got[31];
    bit           to;
    int           w0, cyc;
    logic [255:0] expv;
    w0 = writesSeen;
    stallCycles = 4;
    txQ.delete();
    push_value(256'd5);
    cyc = 0;
    while (!(o_avm_read && o_avm_address == A_RX) && cyc < 2000) begin
      @(negedge i_clk);
      cyc++;
    end
    vectors++; if (!(o_avm_read && o_avm_address == A_RX)) begin miscompares++; $display("FAIL spurious_reach got no rx read want rx read"); end
    spuriousReq++;
    repeat (30) @(negedge i_clk);
    vectors++; if (writesSeen != w0) begin miscompares++; $display("FAIL spurious_write got %0d writes want 0", writesSeen - w0); end
    wait_reply(got, to);
    repeat (40) @(negedge i_clk);
    stallCycles = 0;
    expv = 256'(modexp(5, 7, 33));
    vectors++; if (to) begin miscompares++; $display("FAIL spurious_timeout got %0d bytes want 31", txQ.size()); end
    vectors++; if (writesSeen - w0 != 31) begin miscompares++; $display("FAIL spurious_writes got %0d want 31", writesSeen - w0); end
    for (int k = 0; k < 31; k++) begin
      vectors++;
      if (got[k] !== expv[247-8*k -: 8]) begin
        miscompares++; $display("FAIL spurious_byte%0d got %h want %h", k, got[k], expv[247-8*k -: 8]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0]   got[31];
    bit           to;
    logic [31:0]  n, d, a;
    logic [255:0] expv;
    for (int key = 0; key < 2; key++) begin
      do_reset();
      n = $urandom_range(32'h000F_FFFF, 32'd5) | 32'd1;
      d = $urandom_range(500, 1);
      push_value(256'(n));
      push_value(256'(d));
      for (int msg = 0; msg < 3; msg++) begin
        a = $urandom_range(n - 1, 0);
        stallCycles = $urandom_range(2, 0);
        do_cipher(256'(a), got, to);
        repeat (30) @(negedge i_clk);
        expv = 256'(modexp(64'(a), 64'(d), 64'(n)));
        vectors++; if (to) begin miscompares++; $display("FAIL rand%0d_%0d_timeout got %0d bytes want 31", key, msg, txQ.size()); end
        for (int k = 0; k < 31; k++) begin
          vectors++;
          if (got[k] !== expv[247-8*k -: 8]) begin
            miscompares++; $display("FAIL rand%0d_%0d_byte%0d got %h want %h", key, msg, k, got[k], expv[247-8*k -: 8]);
          end
        end
      end
    end
    stallCycles = 0;
  endtask

  initial begin
    i_rst = 1'b1;
    test_reset();
    test_basic();
    test_same_key();
    test_wait_stall();
    test_poll_block();
    test_reset_midstream();
    test_spurious_finish();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
